// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/grant bundle between the two write-back sources, the
// arbiter, and the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned CNT_W = 16
) ();
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;

    logic              p0_valid;
    logic              p0_ready;
    logic [RD_W-1:0]   p0_rd;
    logic [DATA_W-1:0] p0_data;
    logic              p1_valid;
    logic              p1_ready;
    logic [RD_W-1:0]   p1_rd;
    logic [DATA_W-1:0] p1_data;
    logic              wE;
    logic [RD_W-1:0]   rW;
    logic [DATA_W-1:0] busW;
    logic [CNT_W-1:0]  forced_cnt;

    modport master (
        output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
        input  p0_ready, p1_ready, wE, rW, busW, forced_cnt
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
        output p0_ready, p1_ready, wE, rW, busW, forced_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source arbiter for the register file write port: the pipeline WB stage has
// priority, the long-latency unit is forced through after a bounded wait.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        ARB_PRI0  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  forced_cnt_q, forced_cnt_d;
    logic              we_q;
    logic [RD_W-1:0]   rw_q;
    logic [DATA_W-1:0] busw_q;
    logic              p0_ready_c, p1_ready_c;
    logic              grant0_c, grant1_c;

    // Grants are exactly valid & ready, so a handshake the requester sees is never dropped.
    always_comb begin
        p0_ready_c   = 1'b0;
        p1_ready_c   = 1'b0;
        grant0_c     = 1'b0;
        grant1_c     = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        forced_cnt_d = forced_cnt_q;

        if (rst_n) begin
            p0_ready_c = (state_q == ARB_PRI0) || !bus.p1_valid;
            p1_ready_c = !bus.p0_valid || (state_q == ARB_FORCE);
            grant0_c   = bus.p0_valid && p0_ready_c;
            grant1_c   = bus.p1_valid && p1_ready_c;

            if (!bus.p1_valid || grant1_c) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q < WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end

            if (grant1_c && (state_q == ARB_FORCE) && (forced_cnt_q != '1)) begin
                forced_cnt_d = forced_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ARB_PRI0: begin
                    if (bus.p1_valid && !grant1_c && (wait_cnt_q >= WAIT_TRIP)) begin
                        state_d = ARB_FORCE;
                    end
                end
                ARB_FORCE: begin
                    if (grant1_c || !bus.p1_valid) begin
                        state_d = ARB_PRI0;
                    end
                end
                default: state_d = ARB_PRI0;
            endcase
        end
    end

    // Winner is registered onto the regfile port; writes to r0 update rW/busW but not wE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_PRI0;
            wait_cnt_q   <= '0;
            forced_cnt_q <= '0;
            we_q         <= 1'b0;
            rw_q         <= '0;
            busw_q       <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            forced_cnt_q <= forced_cnt_d;
            if (grant1_c) begin
                we_q   <= |bus.p1_rd;
                rw_q   <= bus.p1_rd;
                busw_q <= bus.p1_data;
            end else if (grant0_c) begin
                we_q   <= |bus.p0_rd;
                rw_q   <= bus.p0_rd;
                busw_q <= bus.p0_data;
            end else begin
                we_q   <= 1'b0;
            end
        end
    end

    assign bus.p0_ready   = p0_ready_c;
    assign bus.p1_ready   = p1_ready_c;
    assign bus.wE         = we_q;
    assign bus.rW         = rw_q;
    assign bus.busW       = busw_q;
    assign bus.forced_cnt = forced_cnt_q;
endmodule
